cgra_context_seq: RTL and testbench

Context sequencer for the CGRA array. It streams 64-bit context words into every tile's context memory over the shared config-write bus (`cfg_wr_addr`/`cfg_wr_data`/`cfg_wr_en`). It then drives the broadcast `context_pc` through the loaded contexts for a programmed number of iterations, and asserts `global_stall` whenever the array must hold. It sits between the host/DMA command path and the tile grid; one instance serves the whole array.

---
 rtl/cgra_context_seq.sv | 167 ++++++++++++++++
 tb/tb_cgra_context_seq.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cgra_context_seq.sv
// Context sequencer for the CGRA array.
// Streams context words into every tile's context memory over the shared
// config-write bus. It then sweeps the broadcast context PC through the loaded
// contexts for a programmed number of iterations.
//
// Handshake: a context word transfers on a rising edge where cfg_in_valid and
// cfg_in_ready are both 1. cfg_in_ready is 1 exactly while the sequencer is in
// LOAD. The producer must hold cfg_in_data stable while cfg_in_valid is 1 and
// no transfer has happened yet. An abort in the same cycle cancels the transfer.
module cgra_context_seq #(
  parameter int PC_WIDTH      = 4,
  parameter int CONTEXT_DEPTH = 16,
  parameter int ITER_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [63:0]           cfg_in_data,
  input  logic                  cfg_in_valid,
  output logic                  cfg_in_ready,
  input  logic                  load_start,
  input  logic [PC_WIDTH:0]     load_count,
  input  logic                  run_start,
  input  logic [ITER_WIDTH-1:0] run_iters,
  input  logic                  abort,
  input  logic                  stall_req,
  output logic [PC_WIDTH-1:0]   cfg_wr_addr,
  output logic [63:0]           cfg_wr_data,
  output logic                  cfg_wr_en,
  output logic [PC_WIDTH-1:0]   context_pc,
  output logic                  global_stall,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ITER_WIDTH-1:0] iter_count,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [PC_WIDTH:0]     DEPTH_L  = CONTEXT_DEPTH[PC_WIDTH:0];
  localparam logic [PC_WIDTH:0]     CNT_ONE  = 1;
  localparam logic [PC_WIDTH-1:0]   PC_ONE   = 1;
  localparam logic [ITER_WIDTH-1:0] ITER_ONE = 1;

  state_t                state, state_next;
  logic                  err_next;
  logic [PC_WIDTH:0]     n_ctx;    // contexts held by the tiles after a complete load
  logic [PC_WIDTH:0]     ld_cnt;   // word count requested by the load in progress
  logic [PC_WIDTH-1:0]   k;        // next context address to write
  logic [ITER_WIDTH-1:0] iters_q;  // iteration target of the current run

  logic cmd, load_ok, run_ok, hs, last_k, last_pc, last_iter;

  assign cmd       = load_start | run_start;
  assign load_ok   = (load_count != '0) && (load_count <= DEPTH_L);
  assign run_ok    = (n_ctx != '0) && (run_iters != '0);
  assign hs        = (state == S_LOAD) && cfg_in_valid && !abort;
  assign last_k    = ({1'b0, k} == (ld_cnt - CNT_ONE));
  assign last_pc   = ({1'b0, context_pc} == (n_ctx - CNT_ONE));
  assign last_iter = ((iter_count + ITER_ONE) == iters_q);

  assign cfg_in_ready = (state == S_LOAD);
  assign busy         = (state == S_LOAD) || (state == S_RUN);
  assign global_stall = (state == S_RUN) ? stall_req : 1'b1;
  assign dbg_state    = state;

  // Next-state and error-pulse decode; abort wins over every command.
  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_start) begin
            if (load_ok) state_next = S_LOAD;
            else         err_next   = 1'b1;
          end
          if (run_start) begin
            if (load_start)  err_next   = 1'b1;
            else if (run_ok) state_next = S_RUN;
            else             err_next   = 1'b1;
          end
        end
        S_LOAD: begin
          err_next = cmd;
          if (hs && last_k) state_next = S_DONE;
        end
        S_RUN: begin
          err_next = cmd;
          if (!stall_req && last_pc && last_iter) state_next = S_DONE;
        end
        S_DONE: begin
          err_next   = cmd;
          state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // State, config-write bus, PC/iteration counters and status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      n_ctx       <= '0;
      ld_cnt      <= '0;
      k           <= '0;
      iters_q     <= '0;
      iter_count  <= '0;
      context_pc  <= '0;
      cfg_wr_addr <= '0;
      cfg_wr_data <= '0;
      cfg_wr_en   <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state     <= state_next;
      err       <= err_next;
      done      <= (state_next == S_DONE);
      cfg_wr_en <= hs;
      if (hs) begin
        cfg_wr_addr <= k;
        cfg_wr_data <= cfg_in_data;
        k           <= k + PC_ONE;
        if (last_k) n_ctx <= ld_cnt;
      end
      if (abort) begin
        // A partial load leaves the tile memories inconsistent.
        if (state == S_LOAD) n_ctx <= '0;
        context_pc <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (load_start && load_ok) begin
              k      <= '0;
              ld_cnt <= load_count;
            end else if (run_start && !load_start && run_ok) begin
              context_pc <= '0;
              iter_count <= '0;
              iters_q    <= run_iters;
            end
          end
          S_RUN: begin
            if (!stall_req) begin
              if (last_pc) begin
                context_pc <= '0;
                iter_count <= iter_count + ITER_ONE;
              end else begin
                context_pc <= context_pc + PC_ONE;
              end
            end
          end
          S_DONE: context_pc <= '0;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cgra_context_seq.sv
// Bench for cgra_context_seq: directed scenarios followed by randomized
// load/run/abort/reset traffic, checked every cycle against a behavioural model.
module tb_cgra_context_seq;

  localparam int PW = 4;
  localparam int IW = 16;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_DONE = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [63:0]   cfg_in_data;
  logic          cfg_in_valid, cfg_in_ready;
  logic          load_start;
  logic [PW:0]   load_count;
  logic          run_start;
  logic [IW-1:0] run_iters;
  logic          abort, stall_req;
  logic [PW-1:0] cfg_wr_addr;
  logic [63:0]   cfg_wr_data;
  logic          cfg_wr_en;
  logic [PW-1:0] context_pc;
  logic          global_stall, busy, done, err;
  logic [IW-1:0] iter_count;
  logic [1:0]    dbg_state;

  cgra_context_seq #(.PC_WIDTH(PW), .CONTEXT_DEPTH(16), .ITER_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_in_data(cfg_in_data), .cfg_in_valid(cfg_in_valid), .cfg_in_ready(cfg_in_ready),
    .load_start(load_start), .load_count(load_count),
    .run_start(run_start), .run_iters(run_iters),
    .abort(abort), .stall_req(stall_req),
    .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data), .cfg_wr_en(cfg_wr_en),
    .context_pc(context_pc), .global_stall(global_stall), .busy(busy),
    .done(done), .err(err), .iter_count(iter_count), .dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // behavioural model: run progress kept as a count of executed slots
  int   m_mode, m_nctx, m_req, m_k, m_exec, m_iters, m_iter_last;
  bit   m_err, m_done, m_wr_en;
  logic [67:0] exp_q[$];  // expected {addr, data} config writes, in order

  function automatic int exp_pc();
    return (m_mode == M_RUN) ? (m_exec % m_nctx) : 0;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_nctx = 0; m_req = 0; m_k = 0; m_exec = 0;
    m_iters = 0; m_iter_last = 0; m_err = 0; m_done = 0; m_wr_en = 0;
    exp_q.delete();
  endtask

  task automatic model_update();
    int lc;
    logic [3:0] kk;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_err = 0; m_done = 0; m_wr_en = 0;
    lc = int'(load_count);
    if (abort) begin
      if (m_mode == M_LOAD) m_nctx = 0;
      m_mode = M_IDLE;
      return;
    end
    case (m_mode)
      M_IDLE: begin
        if (load_start) begin
          if (lc >= 1 && lc <= 16) begin m_mode = M_LOAD; m_k = 0; m_req = lc; end
          else m_err = 1;
        end
        if (run_start) begin
          if (load_start) m_err = 1;
          else if (m_nctx != 0 && run_iters != 0) begin
            m_mode = M_RUN; m_exec = 0; m_iters = int'(run_iters); m_iter_last = 0;
          end else m_err = 1;
        end
      end
      M_LOAD: begin
        m_err = load_start | run_start;
        if (cfg_in_valid) begin
          m_wr_en = 1;
          kk = m_k[3:0];
          exp_q.push_back({kk, cfg_in_data});
          m_k++;
          if (m_k == m_req) begin m_nctx = m_req; m_mode = M_DONE; m_done = 1; end
        end
      end
      M_RUN: begin
        m_err = load_start | run_start;
        if (!stall_req) begin
          m_exec++;
          m_iter_last = m_exec / m_nctx;
          if (m_exec == m_nctx * m_iters) begin m_mode = M_DONE; m_done = 1; end
        end
      end
      default: begin
        m_err = load_start | run_start;
        m_mode = M_IDLE;
      end
    endcase
  endtask

  // one clock: combinational checks before the edge, registered checks after
  task automatic cycle();
    logic [67:0] e;
    #1;
    check("global_stall", global_stall, (m_mode == M_RUN) ? stall_req : 1'b1);
    check("cfg_in_ready", cfg_in_ready, m_mode == M_LOAD);
    check("busy", busy, (m_mode == M_LOAD) || (m_mode == M_RUN));
    @(posedge clk);
    model_update();
    #1;
    check("done", done, m_done);
    check("err", err, m_err);
    check("cfg_wr_en", cfg_wr_en, m_wr_en);
    check("context_pc", context_pc, exp_pc());
    check("iter_count", iter_count, m_iter_last);
    if (cfg_wr_en) begin
      if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("cfg_wr_addr", cfg_wr_addr, e[67:64]);
        check("cfg_wr_data", cfg_wr_data, e[63:0]);
      end
    end
  endtask

  // driver tasks
  task automatic idle(input int n);
    load_start = 0; run_start = 0; abort = 0; cfg_in_valid = 0;
    repeat (n) cycle();
  endtask

  task automatic cmd_load(input logic [PW:0] cnt);
    load_start = 1; load_count = cnt;
    cycle();
    load_start = 0;
  endtask

  task automatic cmd_run(input logic [IW-1:0] it);
    run_start = 1; run_iters = it;
    cycle();
    run_start = 0;
  endtask

  task automatic feed(input logic [63:0] w, input int gap);
    cfg_in_valid = 1; cfg_in_data = w;
    cycle();
    cfg_in_valid = 0;
    repeat (gap) cycle();
  endtask

  task automatic do_abort();
    abort = 1;
    cycle();
    abort = 0;
  endtask

  // runs until done is seen or the budget expires; returns cycles consumed
  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (cycles < budget) begin
      cycle();
      cycles++;
      if (done) return;
    end
    check("wait_done_timeout", 0, 1);
  endtask

  logic [63:0] wa, wb, wc;
  int len, cnt_i, it_i;

  initial begin
    rst_n = 0; cfg_in_data = '0; cfg_in_valid = 0; load_start = 0; load_count = '0;
    run_start = 0; run_iters = '0; abort = 0; stall_req = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_global_stall", global_stall, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cfg_wr_en", cfg_wr_en, 0);
    check("rst_cfg_wr_addr", cfg_wr_addr, 0);
    check("rst_cfg_wr_data", cfg_wr_data, 0);
    check("rst_context_pc", context_pc, 0);
    check("rst_iter_count", iter_count, 0);
    rst_n = 1;
    idle(1);

    // illegal commands out of reset
    cmd_run(2);   check("err_run_nctx0", err, 1);
    cmd_load(0);  check("err_load_cnt0", err, 1);
    cmd_load(17); check("err_load_cnt17", err, 1);
    idle(1);

    // load three words with one-cycle gaps
    wa = 64'hA5A5_0000_1111_2222; wb = 64'hB0B0_3333_4444_5555; wc = 64'hC3C3_6666_7777_8888;
    cmd_load(3);
    feed(wa, 1); feed(wb, 1);
    feed(wc, 0);
    check("load_done_after_last", done, 1);
    check("load_last_addr", cfg_wr_addr, 2);
    check("load_last_data", cfg_wr_data, wc);
    idle(2);
    cmd_run(0); check("err_iters0", err, 1);

    // run without stalls: 3 contexts x 2 iterations
    stall_req = 0;
    cmd_run(2);
    check("run_first_pc", context_pc, 0);
    wait_done(20, len);
    check("run_len_nostall", len, 6);
    check("run_final_iters", iter_count, 2);
    idle(1);

    // same run with four stalled cycles at PC 1
    cmd_run(2);
    cycle();
    stall_req = 1;
    repeat (4) begin cycle(); check("stall_pc_hold", context_pc, 1); end
    stall_req = 0;
    wait_done(20, len);
    check("run_len_stall", len + 5, 10);
    idle(1);

    // run_start during LOAD is rejected and LOAD continues
    cmd_load(4);
    cmd_run(1); check("err_run_in_load", err, 1);
    check("busy_in_load", busy, 1);
    feed({$urandom, $urandom}, 0); feed({$urandom, $urandom}, 0);
    do_abort();
    check("abort_load_busy", busy, 0);
    cmd_run(1); check("err_run_after_abort", err, 1);

    // abort during RUN at PC 2
    cmd_load(3);
    feed({$urandom, $urandom}, 0); feed({$urandom, $urandom}, 0); feed({$urandom, $urandom}, 0);
    idle(1);
    cmd_run(3);
    cycle(); cycle();
    check("pc_before_abort", context_pc, 2);
    do_abort();
    check("abort_run_pc", context_pc, 0);
    check("abort_run_done", done, 0);
    idle(1);

    // reset during RUN
    cmd_run(3);
    idle(2);
    rst_n = 0; cycle(); rst_n = 1;
    check("midrst_busy", busy, 0);
    check("midrst_pc", context_pc, 0);
    cmd_run(1); check("err_run_after_reset", err, 1);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          if ($urandom_range(0, 7) == 0) cnt_i = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 31);
          else cnt_i = $urandom_range(1, 16);
          cmd_load(cnt_i[PW:0]);
          for (int j = 0; j < cnt_i && m_mode == M_LOAD; j++) begin
            if (j > 0 && $urandom_range(0, 24) == 0) begin do_abort(); break; end
            feed({$urandom, $urandom}, $urandom_range(0, 2));
          end
          idle(2);
        end
        4, 5, 6, 7: begin
          it_i = $urandom_range(0, 4);
          cmd_run(it_i[IW-1:0]);
          for (int c = 0; c < 400 && m_mode == M_RUN; c++) begin
            stall_req = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 80) == 0) begin stall_req = 0; do_abort(); end
            else if ($urandom_range(0, 40) == 0) cmd_load($urandom_range(1, 16));
            else cycle();
          end
          stall_req = 0;
          idle(2);
        end
        8: begin
          load_start = 1; run_start = 1;
          load_count = $urandom_range(0, 31); run_iters = $urandom_range(0, 3);
          cycle();
          load_start = 0; run_start = 0;
          check("err_both_cmds", err, 1);
          if (m_mode == M_LOAD) do_abort();
          idle(1);
        end
        default: begin
          rst_n = 0; cycle(); rst_n = 1;
          idle(1);
        end
      endcase
    end

    idle(2);
    check("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
